// File: rtl/risc16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : risc16_pkg
// Description : Shared encodings for the 16-bit RISC multi-cycle control path.
// Revision    : 1.0
// ============================================================================
package risc16_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_NOT = 3'b010;
    localparam logic [2:0] ALU_SHL = 3'b011;
    localparam logic [2:0] ALU_SHR = 3'b100;
    localparam logic [2:0] ALU_AND = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b0001;
    localparam logic [3:0] OP_SW    = 4'b0010;
    localparam logic [3:0] OP_BEQ   = 4'b0011;
    localparam logic [3:0] OP_BNE   = 4'b0100;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_JMP   = 4'b0110;

    localparam logic       SRCA_PC  = 1'b0;
    localparam logic       SRCA_REG = 1'b1;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_ONE   = 2'b01;
    localparam logic [1:0] SRCB_IMM6  = 2'b10;
    localparam logic [1:0] SRCB_IMM12 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op <= OP_JMP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_timer
// Description : Counts unacknowledged memory request cycles; flags a timeout.
// Revision    : 1.0
// ============================================================================
module mem_wait_timer #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic i_ack,
    input  logic i_clear,
    output logic o_timeout
);

    localparam logic [7:0] c_limit = 8'(ACK_TIMEOUT - 1);

    logic [7:0] r_count;

    // An ack arriving on the last allowed cycle still wins over the timeout.
    assign o_timeout = i_req && !i_ack && (r_count == c_limit);

    always_ff @(posedge clk) begin
        if (rst || i_clear || i_ack || !i_req || o_timeout) begin
            r_count <= 8'd0;
        end else begin
            r_count <= r_count + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with memory
//               req/ack handshake and ack-timeout watchdog.
// Revision    : 1.0
// ============================================================================
module multicycle_ctrl
    import risc16_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        zero,
    input  logic        mem_ack,
    output logic [2:0]  alu_control,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        illegal,
    output logic        bus_err,
    output logic [2:0]  state
);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  w_opcode;
    logic [2:0]  w_funct;
    logic        w_timeout;
    logic        w_state_exit;
    logic        w_unused_ir_bits;

    assign w_opcode         = ir[15:12];
    assign w_funct          = ir[2:0];
    assign w_unused_ir_bits = &{1'b0, ir[11:3]};

    // Kept outside the main decode block so the watchdog input has no
    // combinational path back through next-state logic.
    assign mem_req      = !rst && ((r_state == S_FETCH) || (r_state == S_MEM));
    assign w_state_exit = (w_next_state != r_state);
    assign state        = rst ? S_FETCH : r_state;

    mem_wait_timer #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_mem_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .i_req     (mem_req),
        .i_ack     (mem_ack),
        .i_clear   (w_state_exit),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        alu_control  = ALU_ADD;
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_REG;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PCSRC_ALU;
        mem_we       = 1'b0;
        iord         = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        illegal      = 1'b0;
        bus_err      = 1'b0;

        case (r_state)
            S_FETCH: begin
                alu_src_b = SRCB_ONE;
                if (mem_ack) begin
                    ir_write     = 1'b1;
                    pc_write     = 1'b1;
                    w_next_state = S_DECODE;
                end else if (w_timeout) begin
                    bus_err      = 1'b1;
                    w_next_state = S_FETCH;
                end
            end

            S_DECODE: begin
                alu_src_b = SRCB_IMM6;
                if (w_opcode == OP_JMP) begin
                    pc_write     = 1'b1;
                    pc_src       = PCSRC_JUMP;
                    w_next_state = S_FETCH;
                end else if (!is_legal_op(w_opcode)) begin
                    illegal      = 1'b1;
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_EXEC;
                end
            end

            S_EXEC: begin
                alu_src_a = SRCA_REG;
                case (w_opcode)
                    OP_RTYPE: begin
                        alu_control  = w_funct;
                        w_next_state = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src_b    = SRCB_IMM6;
                        w_next_state = S_MEM;
                    end
                    OP_BEQ, OP_BNE: begin
                        alu_control  = ALU_SUB;
                        pc_src       = PCSRC_ALUOUT;
                        pc_write     = (w_opcode == OP_BEQ) ? zero : !zero;
                        w_next_state = S_FETCH;
                    end
                    OP_ADDI: begin
                        alu_src_b    = SRCB_IMM6;
                        w_next_state = S_WB;
                    end
                    default: begin
                        w_next_state = S_FETCH;
                    end
                endcase
            end

            S_MEM: begin
                iord   = 1'b1;
                mem_we = (w_opcode == OP_SW);
                if (mem_ack) begin
                    w_next_state = (w_opcode == OP_LW) ? S_WB : S_FETCH;
                end else if (w_timeout) begin
                    bus_err      = 1'b1;
                    w_next_state = S_FETCH;
                end
            end

            S_WB: begin
                reg_write    = 1'b1;
                reg_dst      = (w_opcode == OP_RTYPE);
                mem_to_reg   = (w_opcode == OP_LW);
                w_next_state = S_FETCH;
            end

            default: begin
                w_next_state = S_FETCH;
            end
        endcase

        // Reset silences every strobe, including ones already decoded this cycle.
        if (rst) begin
            alu_control = 3'b000;
            alu_src_a   = 1'b0;
            alu_src_b   = 2'b00;
            ir_write    = 1'b0;
            pc_write    = 1'b0;
            pc_src      = 2'b00;
            mem_we      = 1'b0;
            iord        = 1'b0;
            reg_write   = 1'b0;
            reg_dst     = 1'b0;
            mem_to_reg  = 1'b0;
            illegal     = 1'b0;
            bus_err     = 1'b0;
        end
    end

endmodule
`default_nettype wire
